// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - EX-stage issue / ID-stage stall bundle for the multiply/divide unit.
interface mult_div_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        md_use_d;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, md_use_d,
      input  busy, stall, hi, lo
   );

   modport slave (
      input  start, op, a, b, md_use_d,
      output busy, stall, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit holding HI/LO with ID-stage stall.
// Define MDU_DIV_EN to build the divider; otherwise div/divu behave as NOP.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   mult_div_unit_if.slave mdu
);
   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]      r_hi, r_lo, r_pend_hi, r_pend_lo;
   logic             r_pend_wr;
   logic             w_is_mul, w_is_div, w_issue, w_done;
   logic [63:0]      w_ext_a, w_ext_b, w_prod;
   logic [31:0]      w_quo, w_rem;
   logic             w_div_wr;

   assign w_is_mul = (mdu.op == OP_MULT) || (mdu.op == OP_MULTU);

   // Sign- or zero-extending to 64 bits lets one unsigned multiplier serve both mult and multu.
   assign w_ext_a = {{32{(mdu.op == OP_MULT) & mdu.a[31]}}, mdu.a};
   assign w_ext_b = {{32{(mdu.op == OP_MULT) & mdu.b[31]}}, mdu.b};
   assign w_prod  = w_ext_a * w_ext_b;

`ifdef MDU_DIV_EN
   logic        w_sgn;
   logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag;

   assign w_is_div = (mdu.op == OP_DIV) || (mdu.op == OP_DIVU);
   assign w_sgn    = (mdu.op == OP_DIV);
   // Magnitude divide then re-sign: gives truncation toward zero and makes 0x80000000/-1 wrap naturally.
   assign w_a_mag  = (w_sgn & mdu.a[31]) ? (32'd0 - mdu.a) : mdu.a;
   assign w_b_mag  = (w_sgn & mdu.b[31]) ? (32'd0 - mdu.b) : mdu.b;
   assign w_q_mag  = (mdu.b == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
   assign w_r_mag  = (mdu.b == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
   assign w_quo    = (w_sgn & (mdu.a[31] ^ mdu.b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem    = (w_sgn & mdu.a[31]) ? (32'd0 - w_r_mag) : w_r_mag;
   assign w_div_wr = (mdu.b != 32'd0);
`else
   assign w_is_div = 1'b0;
   assign w_quo    = 32'd0;
   assign w_rem    = 32'd0;
   assign w_div_wr = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_issue     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mdu.start && (w_is_mul || w_is_div)) begin
               w_issue     = 1'b1;
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = w_is_mul ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
            end
         end
         S_BUSY: begin
            if (r_cnt == '0) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_wr <= 1'b0;
      end else begin
         if (w_issue) begin
            r_pend_hi <= w_is_mul ? w_prod[63:32] : w_rem;
            r_pend_lo <= w_is_mul ? w_prod[31:0]  : w_quo;
            r_pend_wr <= w_is_mul | w_div_wr;
         end
         if (w_done && r_pend_wr) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
         if ((r_state == S_IDLE) && mdu.start && (mdu.op == OP_MTHI)) r_hi <= mdu.a;
         if ((r_state == S_IDLE) && mdu.start && (mdu.op == OP_MTLO)) r_lo <= mdu.a;
      end
   end

   assign mdu.busy  = (r_state == S_BUSY);
   assign mdu.stall = mdu.md_use_d & (mdu.busy | (mdu.start & (w_is_mul | w_is_div)));
   assign mdu.hi    = r_hi;
   assign mdu.lo    = r_lo;
endmodule
